// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS controller: ALU codes, opcodes, functs, FSM states, mux encodings.
// MC_CTRL_BNE_EN (optional) adds bne (opcode 0x05) to the DECODE dispatch.
package mips_pkg;

  localparam int ALU_CODE_W = 3;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_EQU = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEX, S_RTWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  // DECODE target for an opcode; S_FETCH means the opcode is unsupported.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_RTEX;
      OP_ADDI:      nxt = S_ADDIEX;
      OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:       nxt = S_BRANCH;
`endif
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to an ALU code and flags unsupported functs.
module mc_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_code,
  output logic       funct_ok
);

  always_comb begin
    alu_code = ALU_AND;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_SLT:  alu_code = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional MC_CTRL_BNE_EN adds bne, resolved in BRANCH with the inverted zero flag.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             flagZ,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_sel,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal
);

  state_t     state;
  logic [2:0] rt_code;
  logic       rt_ok;
  logic [2:0] alu_code;

  mc_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_code (rt_code),
    .funct_ok (rt_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= decode_dispatch(opcode);
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_RTEX:   state <= rt_ok ? S_RTWB : S_FETCH;
        S_RTWB:   state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign alu_sel = ALU_W'(alu_code);

  // Moore decode; only FETCH/MEMWR (mem_ready) and BRANCH (flagZ) look at live inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_code   = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_code  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_code  = ALU_ADD;
        illegal   = (decode_dispatch(opcode) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_code  = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_code  = rt_ok ? rt_code : ALU_AND;
        illegal   = ~rt_ok;
      end
      S_RTWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_code   = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        instr_done = 1'b1;
`ifdef MC_CTRL_BNE_EN
        pc_write   = (opcode == OP_BNE) ? ~flagZ : flagZ;
`else
        pc_write   = flagZ;
`endif
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle input/expected-output rows, compared through a scoreboard queue.
module tb_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       flagZ = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_sel;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;

  always #5 clk = ~clk;

  mc_ctrl #(.ALU_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .flagZ      (flagZ),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_sel    (alu_sel),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  // {mem_req,mem_write,iord,ir_write,pc_write,pc_src,alu_src_a,alu_src_b,alu_sel,reg_write,reg_dst,mem_to_reg,instr_done,illegal}
  logic [17:0] act;
  assign act = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                alu_sel, reg_write, reg_dst, mem_to_reg, instr_done, illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        fz;
    logic        mr;
    logic [17:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [17:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [17:0] o_fetch_w, o_fetch_r, o_dec, o_dec_ill, o_madr, o_mrd, o_mwb, o_mwr_w, o_mwr_r;
  logic [17:0] o_rtwb, o_rtex_ill, o_addiex, o_addiwb, o_br_t, o_br_n, o_jump;

  function automatic logic [17:0] pk(input logic req, input logic wr, input logic ad, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] alu, input logic rw,
                                     input logic rd, input logic m2r, input logic done, input logic ill);
    return {req, wr, ad, irw, pcw, pcs, sa, sb, alu, rw, rd, m2r, done, ill};
  endfunction

  function automatic logic [17:0] o_rtex(input logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, alu, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic fz, input logic mr,
                     input logic [17:0] exp, input string name);
    vec_t v;
    v.op = op; v.fn = fn; v.fz = fz; v.mr = mr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic expect_cycle(input logic [17:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    opcode = v.op; funct = v.fn; flagZ = v.fz; mem_ready = v.mr;
    expect_cycle(v.exp, v.name);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu, input string name);
    add(OP_RTYPE, fn, 0, 1, o_fetch_r, {name, "_fetch"});
    add(OP_RTYPE, fn, 0, 1, o_dec,     {name, "_decode"});
    add(OP_RTYPE, fn, 0, 1, o_rtex(alu), {name, "_rtex"});
    add(OP_RTYPE, fn, 0, 1, o_rtwb,    {name, "_rtwb"});
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %05h", e.name, act);
      end
    end
  end

  initial begin
    vec_t v;
    o_fetch_w  = pk(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
    o_fetch_r  = pk(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
    o_dec      = pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, 0);
    o_dec_ill  = pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, 1);
    o_madr     = pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0);
    o_mrd      = pk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    o_mwb      = pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 1, 0);
    o_mwr_w    = pk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    o_mwr_r    = pk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    o_rtwb     = pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0, 1, 0);
    o_rtex_ill = pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b000, 0, 0, 0, 0, 1);
    o_addiex   = pk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0);
    o_addiwb   = pk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0, 1, 0);
    o_br_t     = pk(0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 1, 0);
    o_br_n     = pk(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 1, 0);
    o_jump     = pk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0);

    // Vector table: one row per clock cycle, starting from the first FETCH after reset.
    rtype(FN_SUB, 3'b110, "sub");
    add(OP_LW, 0, 0, 1, o_fetch_r, "lw_fetch");
    add(OP_LW, 0, 0, 1, o_dec,     "lw_decode");
    add(OP_LW, 0, 0, 1, o_madr,    "lw_memadr");
    add(OP_LW, 0, 0, 0, o_mrd,     "lw_memrd_wait1");
    add(OP_LW, 0, 0, 0, o_mrd,     "lw_memrd_wait2");
    add(OP_LW, 0, 0, 1, o_mrd,     "lw_memrd_ready");
    add(OP_LW, 0, 0, 1, o_mwb,     "lw_memwb");
    add(OP_SW, 0, 0, 0, o_fetch_w, "sw_fetch_wait");
    add(OP_SW, 0, 0, 1, o_fetch_r, "sw_fetch");
    add(OP_SW, 0, 0, 1, o_dec,     "sw_decode");
    add(OP_SW, 0, 0, 1, o_madr,    "sw_memadr");
    add(OP_SW, 0, 0, 0, o_mwr_w,   "sw_memwr_wait");
    add(OP_SW, 0, 0, 1, o_mwr_r,   "sw_memwr_ready");
    add(OP_ADDI, 0, 0, 1, o_fetch_r, "addi_fetch");
    add(OP_ADDI, 0, 0, 1, o_dec,     "addi_decode");
    add(OP_ADDI, 0, 0, 1, o_addiex,  "addi_ex");
    add(OP_ADDI, 0, 0, 1, o_addiwb,  "addi_wb");
    add(OP_BEQ, 0, 0, 1, o_fetch_r, "beq_t_fetch");
    add(OP_BEQ, 0, 0, 1, o_dec,     "beq_t_decode");
    add(OP_BEQ, 0, 1, 1, o_br_t,    "beq_taken");
    add(OP_BEQ, 0, 1, 1, o_fetch_r, "beq_n_fetch");
    add(OP_BEQ, 0, 1, 1, o_dec,     "beq_n_decode");
    add(OP_BEQ, 0, 0, 1, o_br_n,    "beq_not_taken");
    add(OP_J, 0, 0, 1, o_fetch_r, "j_fetch");
    add(OP_J, 0, 0, 1, o_dec,     "j_decode");
    add(OP_J, 0, 0, 1, o_jump,    "j_jump");
    add(6'h3F, 0, 0, 1, o_fetch_r, "badop_fetch");
    add(6'h3F, 0, 0, 1, o_dec_ill, "badop_decode_illegal");
    add(OP_RTYPE, 6'h03, 0, 1, o_fetch_r,  "badfn_fetch");
    add(OP_RTYPE, 6'h03, 0, 1, o_dec,      "badfn_decode");
    add(OP_RTYPE, 6'h03, 0, 1, o_rtex_ill, "badfn_rtex_illegal");
    rtype(FN_ADD, 3'b010, "add");
    rtype(FN_AND, 3'b000, "and");
    rtype(FN_OR,  3'b001, "or");
    rtype(FN_SLT, 3'b111, "slt");
    add(OP_BNE, 0, 0, 1, o_fetch_r, "bne_fetch");
`ifdef MC_CTRL_BNE_EN
    add(OP_BNE, 0, 0, 1, o_dec,     "bne_decode");
    add(OP_BNE, 0, 0, 1, o_br_t,    "bne_taken");
    add(OP_BNE, 0, 1, 1, o_fetch_r, "bne2_fetch");
    add(OP_BNE, 0, 1, 1, o_dec,     "bne2_decode");
    add(OP_BNE, 0, 1, 1, o_br_n,    "bne_not_taken");
`else
    add(OP_BNE, 0, 0, 1, o_dec_ill, "bne_decode_illegal");
`endif
    add(OP_SW, 0, 0, 1, o_fetch_r, "rst_sw_fetch");
    add(OP_SW, 0, 0, 1, o_dec,     "rst_sw_decode");
    add(OP_SW, 0, 0, 1, o_madr,    "rst_sw_memadr");
    add(OP_SW, 0, 0, 0, o_mwr_w,   "rst_sw_memwr_wait");

    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act !== 18'h0) begin
      errors++;
      $display("FAIL reset_hold: got %05h expected %05h", act, 18'h0);
    end
    rst_n = 1'b1;
    expect_cycle(18'h0, "idle_after_release");

    foreach (vecs[i]) step(vecs[i]);

    // Reset asserted in the middle of a stalled store must drop the request immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== 18'h0) begin
      errors++;
      $display("FAIL async_reset_memwr: got %05h expected %05h", act, 18'h0);
    end else begin
      $display("ok   async_reset_memwr: %05h", act);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    expect_cycle(18'h0, "idle_after_midreset");
    v.op = OP_SW; v.fn = 0; v.fz = 0; v.mr = 1;
    v.exp = o_fetch_r; v.name = "restart_fetch";  step(v);
    v.exp = o_dec;     v.name = "restart_decode"; step(v);
    v.exp = o_madr;    v.name = "restart_memadr"; step(v);
    v.exp = o_mwr_r;   v.name = "restart_memwr";  step(v);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback. It drives `alu_sel` into the datapath ALU and consumes the ALU's `flagZ` for branch resolution. It also issues the datapath mux selects, register and memory write strobes, and a memory request/ready handshake. It sits beside the multi-cycle datapath: instruction register, register file, ALU, PC and unified memory port.

## Interface
- `ALU_W`, 3, width of the `alu_sel` code.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `opcode  in  6`: IR[31:26]. Valid from DECODE onward.
- `funct  in  6`: IR[5:0]. Valid from DECODE onward.
- `flagZ  in  1`: ALU zero flag. Combinational from the current `alu_sel` and operands.
- `mem_ready  in  1`: memory completes the current request this cycle.
- `mem_req  out  1`: memory access request. Held high until `mem_ready`.
- `mem_write  out  1`: the current request is a write.
- `iord  out  1`: address select. 0 = PC, 1 = ALUOut.
- `ir_write  out  1`: load the instruction register.
- `pc_write  out  1`: load the PC.
- `pc_src  out  2`: PC source. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a  out  1`: ALU A select. 0 = PC, 1 = rs.
- `alu_src_b  out  2`: ALU B select. 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_sel  out  3`: ALU operation.
- `reg_write  out  1`: register file write.
- `reg_dst  out  1`: destination select. 0 = rt, 1 = rd.
- `mem_to_reg  out  1`: writeback source. 0 = ALUOut, 1 = MDR.
- `instr_done  out  1`: one-cycle pulse when an instruction retires.
- `illegal  out  1`: one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP.
- ALU codes are fixed: AND=000, OR=001, ADD=010, EQU=101, SUB=110, SLT=111.
- Reset: state is IDLE and every output is 0, including `alu_sel`=000. IDLE always moves to FETCH on the next cycle.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_sel`=ADD, `pc_src`=00.
  - Holds while `mem_ready`=0.
  - In the cycle `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_sel`=ADD, which computes the branch target into ALUOut.
  - Dispatch: opcode 0x23 or 0x2B → MEMADR; 0x00 → RTEX; 0x08 → ADDIEX; 0x04 → BRANCH; 0x02 → JUMP.
  - Any other opcode: `illegal`=1, go to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=ADD. Go to MEMRD if opcode is 0x23, otherwise MEMWR.
- MEMRD: `mem_req`=1, `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1, then go to FETCH.
- MEMWR: `mem_req`=1, `mem_write`=1, `iord`=1. Hold until `mem_ready`. On `mem_ready`, pulse `instr_done` and go to FETCH.
- RTEX:
  - Drives `alu_src_a`=1, `alu_src_b`=00.
  - Funct map: 0x20 → ADD, 0x22 → SUB, 0x24 → AND, 0x25 → OR, 0x2A → SLT. Go to RTWB.
  - Any other funct: `alu_sel`=000, `illegal`=1, go to FETCH with no writeback.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1, then go to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=ADD, then go to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `instr_done`=1, then go to FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_sel`=SUB, `pc_src`=01.
  - `pc_write` = `flagZ` (combinational in the same cycle). Pulse `instr_done`, go to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1, then go to FETCH.
- Any output not listed for a state is 0 in that state.

## Timing
- Outputs are decoded from the state register. The only input-dependent outputs are:
  - `pc_write` and `ir_write` in FETCH, which depend on `mem_ready`;
  - `pc_write` in BRANCH, which depends on `flagZ`;
  - `instr_done` in MEMWR, which depends on `mem_ready`.
- `mem_req` stays asserted across wait cycles. Address and `mem_write` are stable while `mem_req`=1.
- Cycle counts with zero wait states, FETCH through the retire state:

  | Instruction | Cycles |
  |---|---|
  | R-type | 4 |
  | addi | 4 |
  | lw | 5 |
  | sw | 4 |
  | beq | 3 |
  | j | 3 |

  Each cycle with `mem_ready`=0 adds one cycle.
- Asserting `rst_n` low mid-instruction returns the FSM immediately to IDLE with all outputs 0. No partial write is completed after reset.
- An unknown state encoding recovers to IDLE.

## Configuration
- `MC_CTRL_BNE_EN` defined: opcode 0x05 dispatches from DECODE to BRANCH, and in BRANCH `pc_write` = ~`flagZ`.
- `MC_CTRL_BNE_EN` undefined: opcode 0x05 is illegal (`illegal` pulse in DECODE, then FETCH).

## Structure
- Shared package `mips_pkg` holds:
  - the ALU code constants (AND, OR, ADD, EQU, SUB, SLT);
  - the opcode and funct constants;
  - the state enum;
  - the `alu_src_b` and `pc_src` encodings.
- One sub-module, `mc_alu_dec`: combinational funct → `alu_sel` plus a funct-valid flag, used in RTEX.

## Test plan
- **Reset and R-type:** reset released, then opcode 0x00 with funct 0x22 and `mem_ready`=1 constantly.
  - Expect IDLE → FETCH → DECODE → RTEX → RTWB.
  - Expect `alu_sel`=110 in RTEX, then `reg_write`=1 with `reg_dst`=1, and `instr_done` in cycle 5 after reset release.
- **lw with waits:** opcode 0x23, `mem_ready` low for 2 cycles in MEMRD.
  - Expect `mem_req`=1 and `iord`=1 held for 3 cycles.
  - Then MEMWB with `mem_to_reg`=1 and `reg_write`=1.
- **beq taken / not taken:** opcode 0x04.
  - `flagZ`=1 → `pc_write`=1, `pc_src`=01.
  - `flagZ`=0 → `pc_write`=0. `instr_done` pulses in both cases.
- **Illegal encodings:**
  - opcode 0x3F → `illegal` pulse in DECODE, next state FETCH, no `reg_write`.
  - opcode 0x00 with funct 0x03 → `illegal` pulse in RTEX, no `reg_write`.
- **Reset mid-store:** `rst_n` driven low during MEMWR with `mem_ready`=0.
  - Expect `mem_req` and `mem_write` to fall to 0 asynchronously, and the FSM to restart at IDLE.
- **bne (`MC_CTRL_BNE_EN` defined):** opcode 0x05 with `flagZ`=0.
  - Expect `pc_write`=1.
  - With the macro undefined, expect an `illegal` pulse instead.
